call_dispatcher: RTL and testbench
==================================

# call_dispatcher

Collects hall calls (floor panels) and cab calls (car panel) into pending-request registers. Selects the next target floor with a direction-preserving (SCAN) policy and drives the lift controller's `pass_f` / `butt_el` inputs. Clears a request when the car reports arrival at that floor. Sits directly upstream of the lift controller and consumes its `elev_f_o` / `busy_o` feedback.

## Interface
- `N_FLOORS`, 7: served floors, numbered 1..N_FLOORS. Floor code 0 means "no request". Legal range 2..7.
- `FW`, 3: floor-code width.
- `DWELL_CYCLES`, 4: door dwell after arrival. Only present with `CALL_DISP_DWELL_EN`.
- `clk`  in  1  single system clock.
- `rst`  in  1  synchronous, active-high reset.
- `hall_btn_i`  in  N_FLOORS  hall call pulses. Bit k-1 = floor k.
- `cab_btn_i`  in  N_FLOORS  cab call pulses. Bit k-1 = floor k.
- `elev_f_i`  in  FW  current car floor, from the controller's `elev_f_o`.
- `busy_i`  in  1  controller busy, from the controller's `busy_o`.
- `pass_f_o`  out  FW  hall target for the controller (0 = none).
- `butt_el_o`  out  FW  cab target for the controller (0 = none).
- `dir_up_o`  out  1  current sweep direction (1 = up).
- `hall_pend_o`  out  N_FLOORS  pending hall requests, for panel lamps.
- `cab_pend_o`  out  N_FLOORS  pending cab requests, for panel lamps.

## Operation
- Request latch
  - Any set button bit sets the matching pending bit on the next edge.
  - Bits for floor 0 or floors above N_FLOORS do not exist.
  - Repeated presses are idempotent.
- Selection, evaluated from registered pending bits, `elev_f_i` and `dir_up`:
  - If `dir_up`: pick the lowest pending floor ≥ `elev_f_i`.
  - Otherwise: pick the highest pending floor ≤ `elev_f_i`.
  - If none qualifies, reverse direction and repeat. If still none, the target is 0.
- Hall and cab requests use separate selections. Cab takes precedence while the car is occupied (state CAB).
- FSM states:
  - IDLE
    - Outputs 0.
    - Any pending bit → HALL if a hall bit is set, otherwise CAB.
  - HALL
    - `pass_f_o` = hall selection; `butt_el_o` = 0.
    - Arrival → clear that hall bit, go to DWELL, next phase CAB.
  - CAB
    - `butt_el_o` = cab selection; `pass_f_o` = 0.
    - Arrival → clear that cab bit, go to DWELL, next phase HALL if any hall bit is set, otherwise CAB.
    - No cab bit pending → HALL if a hall bit is set, otherwise IDLE.
  - DWELL
    - Outputs hold the just-served floor.
    - Exit to the recorded next phase after the dwell condition (see Configuration).
    - Go to IDLE if nothing is pending.
- Arrival: `elev_f_i` == active target, target ≠ 0, and `busy_i` == 0, sampled on the same edge.
- `dir_up` is updated only when a new target is registered: set to (target > `elev_f_i`). It is unchanged when target == `elev_f_i`.

## Timing
- Reset values:
  - State IDLE.
  - All pending bits 0.
  - `pass_f_o` = 0, `butt_el_o` = 0.
  - `dir_up_o` = 1.
- All outputs are registered.
- Button to pending-bit visibility: 1 cycle.
- Button to first non-zero target from IDLE: 2 cycles.
- Target is frozen while not at the target: a newly pending floor never preempts the current target mid-travel. It is picked up at the next selection.
- Simultaneous set and clear of the same bit on one edge: set wins. The request is re-served later.
- Press for the floor the car is parked on with `busy_i` = 0: served as a normal request. Arrival fires on the edge after the target registers.
- Reset mid-operation: all requests are discarded and outputs return to 0 on the next edge. The controller is reset independently.
- `elev_f_i` outside 1..N_FLOORS: treated as no arrival. Selection saturates to the range.

## Configuration
- `CALL_DISP_DWELL_EN` defined:
  - DWELL counts `DWELL_CYCLES` clocks, then exits.
  - New presses are still latched during the count.
- `CALL_DISP_DWELL_EN` undefined:
  - DWELL lasts exactly 1 cycle.
  - The `DWELL_CYCLES` parameter and its counter are absent.

## Structure
- Package `lift_pkg` holds:
  - `FW`, `N_FLOORS` defaults
  - floor typedef `floor_t`
  - FSM state encoding `disp_state_t` (IDLE, HALL, CAB, DWELL)
  - constant `FLOOR_NONE` = 0
- Sub-module `scan_select`: purely combinational. Inputs: pending mask, current floor, direction. Outputs: target floor and resulting direction. Instantiated twice, once for hall and once for cab.

## Test plan
- Reset, then press hall floor 5 with the car at 1 → `pass_f_o` = 5 two cycles later. Hold `elev_f_i` = 5, `busy_i` = 0 → hall bit 5 clears, state goes to DWELL.
- Car at 3 with `dir_up` = 1; cab presses 2, 6, 4 together → targets served in order 4, 6, 2. `dir_up_o` drops to 0 before 2.
- Press hall 4 on the exact edge hall bit 4 clears on arrival → bit 4 remains set and is served again.
- While travelling to 6, press cab 5 → target stays 6. Next target is 5.
- Assert `rst` mid-CAB with three pending bits → next edge: all pending bits 0, outputs 0, `dir_up_o` = 1.
- With `CALL_DISP_DWELL_EN`, `DWELL_CYCLES` = 4 → the next target appears exactly 4 cycles after arrival. Without the macro → after 1 cycle.

Source files
------------

// File: rtl/lift_pkg.sv
// rtl/lift_pkg.sv - shared floor types and dispatcher state encoding
package lift_pkg;

  localparam int FW       = 3;
  localparam int N_FLOORS = 7;

  typedef logic [FW-1:0] floor_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HALL  = 2'd1,
    CAB   = 2'd2,
    DWELL = 2'd3
  } disp_state_t;

  localparam floor_t FLOOR_NONE = '0;

endpackage

// File: rtl/call_dispatcher_scan_select.sv
// rtl/call_dispatcher_scan_select.sv - combinational SCAN target picker
module scan_select
  import lift_pkg::*;
#(
  parameter int N_FLOORS = lift_pkg::N_FLOORS,
  parameter int FW       = lift_pkg::FW
) (
  input  logic [N_FLOORS-1:0] pend_i,
  input  logic [FW-1:0]       cur_i,
  input  logic                dir_up_i,
  output logic [FW-1:0]       tgt_o,
  output logic                dir_up_o
);

  localparam logic [FW-1:0] TOP_F = FW'(N_FLOORS);

  logic [FW-1:0] cur_sat;
  logic [FW-1:0] up_hit;
  logic [FW-1:0] dn_hit;

  always_comb begin
    cur_sat = cur_i;
    if (cur_i == FLOOR_NONE) begin
      cur_sat = FW'(1);
    end else if (cur_i > TOP_F) begin
      cur_sat = TOP_F;
    end

    // Descending scan leaves the lowest hit above, ascending the highest hit below.
    up_hit = FLOOR_NONE;
    for (int k = N_FLOORS; k >= 1; k--) begin
      if (pend_i[k-1] && (FW'(k) >= cur_sat)) up_hit = FW'(k);
    end
    dn_hit = FLOOR_NONE;
    for (int k = 1; k <= N_FLOORS; k++) begin
      if (pend_i[k-1] && (FW'(k) <= cur_sat)) dn_hit = FW'(k);
    end

    if (dir_up_i) tgt_o = (up_hit != FLOOR_NONE) ? up_hit : dn_hit;
    else          tgt_o = (dn_hit != FLOOR_NONE) ? dn_hit : up_hit;

    if (tgt_o > cur_i)      dir_up_o = 1'b1;
    else if (tgt_o < cur_i) dir_up_o = 1'b0;
    else                    dir_up_o = dir_up_i;
  end

endmodule

// File: rtl/call_dispatcher.sv
// rtl/call_dispatcher.sv - hall/cab request latch and SCAN dispatcher
// CALL_DISP_DWELL_EN: door dwell of DWELL_CYCLES clocks instead of one.
module call_dispatcher
  import lift_pkg::*;
#(
  parameter int N_FLOORS = lift_pkg::N_FLOORS,
  parameter int FW       = lift_pkg::FW
`ifdef CALL_DISP_DWELL_EN
  ,
  parameter int DWELL_CYCLES = 4
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] hall_btn_i,
  input  logic [N_FLOORS-1:0] cab_btn_i,
  input  logic [FW-1:0]       elev_f_i,
  input  logic                busy_i,
  output logic [FW-1:0]       pass_f_o,
  output logic [FW-1:0]       butt_el_o,
  output logic                dir_up_o,
  output logic [N_FLOORS-1:0] hall_pend_o,
  output logic [N_FLOORS-1:0] cab_pend_o
);

  localparam logic [FW-1:0] TOP_F = FW'(N_FLOORS);

  logic [N_FLOORS-1:0] hall_q, hall_d, cab_q, cab_d, hall_clr, cab_clr;
  logic [FW-1:0]       pass_q, pass_d, butt_q, butt_d, hall_tgt, cab_tgt;
  logic                dir_q, dir_d, hall_dir, cab_dir;
  logic                car_ok, arrive_hall, arrive_cab, dwell_done, do_enter;
  disp_state_t         state_q, state_d, next_q, next_d, enter;

  scan_select #(.N_FLOORS(N_FLOORS), .FW(FW)) u_hall_sel (
    .pend_i(hall_q), .cur_i(elev_f_i), .dir_up_i(dir_q), .tgt_o(hall_tgt), .dir_up_o(hall_dir)
  );

  scan_select #(.N_FLOORS(N_FLOORS), .FW(FW)) u_cab_sel (
    .pend_i(cab_q), .cur_i(elev_f_i), .dir_up_i(dir_q), .tgt_o(cab_tgt), .dir_up_o(cab_dir)
  );

  assign car_ok      = !busy_i && (elev_f_i != FLOOR_NONE) && (elev_f_i <= TOP_F);
  assign arrive_hall = car_ok && (pass_q != FLOOR_NONE) && (elev_f_i == pass_q);
  assign arrive_cab  = car_ok && (butt_q != FLOOR_NONE) && (elev_f_i == butt_q);

  function automatic logic [N_FLOORS-1:0] floor_mask(logic [FW-1:0] f);
    floor_mask = '0;
    for (int k = 1; k <= N_FLOORS; k++) begin
      if (f == FW'(k)) floor_mask[k-1] = 1'b1;
    end
  endfunction

  // A preferred CAB phase only sticks while cab work remains.
  function automatic disp_state_t pick_phase(disp_state_t pref, logic any_h, logic any_c);
    if (pref == CAB && any_c) return CAB;
    if (any_h) return HALL;
    if (any_c) return CAB;
    return IDLE;
  endfunction

`ifdef CALL_DISP_DWELL_EN
  localparam int CW = $clog2(DWELL_CYCLES) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  assign cnt_d      = (state_q == DWELL) ? cnt_q + 1'b1 : '0;
  assign dwell_done = (cnt_q == CW'(DWELL_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign dwell_done = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    next_d   = next_q;
    pass_d   = pass_q;
    butt_d   = butt_q;
    dir_d    = dir_q;
    hall_clr = '0;
    cab_clr  = '0;
    enter    = IDLE;
    do_enter = 1'b0;
    case (state_q)
      IDLE: begin
        if (|hall_q || |cab_q) begin
          do_enter = 1'b1;
          enter    = pick_phase(HALL, |hall_q, |cab_q);
        end
      end
      HALL: begin
        if (arrive_hall) begin
          hall_clr = floor_mask(pass_q);
          state_d  = DWELL;
          next_d   = CAB;
        end
      end
      CAB: begin
        if (~|cab_q) begin
          do_enter = 1'b1;
          enter    = pick_phase(HALL, |hall_q, 1'b0);
        end else if (arrive_cab) begin
          cab_clr = floor_mask(butt_q);
          state_d = DWELL;
          next_d  = (|hall_q) ? HALL : CAB;
        end
      end
      default: begin
        if (dwell_done) begin
          do_enter = 1'b1;
          enter    = pick_phase(next_q, |hall_q, |cab_q);
        end
      end
    endcase

    // Targets are only registered on phase entry, so they stay frozen in flight.
    if (do_enter) begin
      state_d = enter;
      pass_d  = FLOOR_NONE;
      butt_d  = FLOOR_NONE;
      if (enter == HALL) begin
        pass_d = hall_tgt;
        dir_d  = hall_dir;
      end else if (enter == CAB) begin
        butt_d = cab_tgt;
        dir_d  = cab_dir;
      end
    end
  end

  assign hall_d = (hall_q & ~hall_clr) | hall_btn_i;
  assign cab_d  = (cab_q & ~cab_clr) | cab_btn_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      next_q  <= HALL;
      hall_q  <= '0;
      cab_q   <= '0;
      pass_q  <= FLOOR_NONE;
      butt_q  <= FLOOR_NONE;
      dir_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      next_q  <= next_d;
      hall_q  <= hall_d;
      cab_q   <= cab_d;
      pass_q  <= pass_d;
      butt_q  <= butt_d;
      dir_q   <= dir_d;
    end
  end

  assign pass_f_o    = pass_q;
  assign butt_el_o   = butt_q;
  assign dir_up_o    = dir_q;
  assign hall_pend_o = hall_q;
  assign cab_pend_o  = cab_q;

endmodule

// File: tb/tb_call_dispatcher.sv
// tb/tb_call_dispatcher.sv - vector table, corner sequences and random model check
module tb_call_dispatcher;

  localparam int N  = 7;
  localparam int FW = 3;
`ifdef CALL_DISP_DWELL_EN
  localparam int DW = 4;
`else
  localparam int DW = 1;
`endif

  localparam int P_IDLE  = 0;
  localparam int P_HALL  = 1;
  localparam int P_CAB   = 2;
  localparam int P_DWELL = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  hall_btn, cab_btn, hall_pend, cab_pend;
  logic [FW-1:0] elev, pass_f, butt_el;
  logic          busy, dir_up;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  call_dispatcher dut (
    .clk(clk), .rst(rst), .hall_btn_i(hall_btn), .cab_btn_i(cab_btn),
    .elev_f_i(elev), .busy_i(busy), .pass_f_o(pass_f), .butt_el_o(butt_el),
    .dir_up_o(dir_up), .hall_pend_o(hall_pend), .cab_pend_o(cab_pend)
  );

  typedef struct {
    logic [N-1:0] hall;
    logic [N-1:0] cab;
    int           elev;
    bit           busy;
    int           pass;
    int           butt;
    bit           dir;
    logic [N-1:0] hp;
    logic [N-1:0] cp;
  } vec_t;

  vec_t vq[$];

  function automatic logic [N-1:0] fm(int f);
    logic [N-1:0] m;
    m = '0;
    if (f >= 1 && f <= N) m[f-1] = 1'b1;
    return m;
  endfunction

  function automatic void addv(logic [N-1:0] h, logic [N-1:0] c, int e, bit b,
                               int p, int bu, bit d, logic [N-1:0] hp, logic [N-1:0] cp);
    vec_t v;
    v.hall = h; v.cab = c; v.elev = e; v.busy = b;
    v.pass = p; v.butt = bu; v.dir = d; v.hp = hp; v.cp = cp;
    vq.push_back(v);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_outs(string tag, int ep, int eb, bit ed, logic [N-1:0] ehp, logic [N-1:0] ecp);
    chk({tag, ".pass_f"}, pass_f, ep);
    chk({tag, ".butt_el"}, butt_el, eb);
    chk({tag, ".dir_up"}, dir_up, ed);
    chk({tag, ".hall_pend"}, hall_pend, ehp);
    chk({tag, ".cab_pend"}, cab_pend, ecp);
  endtask

  task automatic drive(logic [N-1:0] h, logic [N-1:0] c, int e, bit b);
    hall_btn = h;
    cab_btn  = c;
    elev     = FW'(e);
    busy     = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive('0, '0, 1, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  // Behavioural reference: pending sets indexed by floor, SCAN choice by distance score.
  bit [N:1] mh, mc;
  int       m_phase, m_after, m_wait, m_pass, m_butt;
  bit       m_dir;

  function automatic void m_reset();
    mh = '0; mc = '0;
    m_phase = P_IDLE; m_after = P_HALL; m_wait = 0;
    m_pass = 0; m_butt = 0; m_dir = 1'b1;
  endfunction

  function automatic int m_pick(bit [N:1] p, int cur, bit up);
    int c = (cur < 1) ? 1 : ((cur > N) ? N : cur);
    int best = 0;
    int best_score = 1 << 20;
    int s;
    for (int f = 1; f <= N; f++) begin
      if (p[f]) begin
        if (up) s = (f >= c) ? f - c : 100 + c - f;
        else    s = (f <= c) ? c - f : 100 + f - c;
        if (s < best_score) begin
          best_score = s;
          best = f;
        end
      end
    end
    return best;
  endfunction

  function automatic bit m_arrive(int tgt, int e, bit b);
    return tgt != 0 && e == tgt && !b && e >= 1 && e <= N;
  endfunction

  function automatic void m_step(bit [N:1] h, bit [N:1] c, int e, bit b);
    bit ah = |mh;
    bit ac = |mc;
    int go = -1;
    int clr_h = 0;
    int clr_c = 0;
    int t;
    case (m_phase)
      P_IDLE: if (ah || ac) go = ah ? P_HALL : P_CAB;
      P_HALL: begin
        if (m_arrive(m_pass, e, b)) begin
          clr_h = m_pass; m_phase = P_DWELL; m_after = P_CAB; m_wait = 0;
        end
      end
      P_CAB: begin
        if (!ac) go = ah ? P_HALL : P_IDLE;
        else if (m_arrive(m_butt, e, b)) begin
          clr_c = m_butt; m_phase = P_DWELL; m_after = ah ? P_HALL : P_CAB; m_wait = 0;
        end
      end
      default: begin
        m_wait++;
        if (m_wait >= DW)
          go = (m_after == P_CAB && ac) ? P_CAB : (ah ? P_HALL : (ac ? P_CAB : P_IDLE));
      end
    endcase
    if (go >= 0) begin
      t = (go == P_HALL) ? m_pick(mh, e, m_dir) : ((go == P_CAB) ? m_pick(mc, e, m_dir) : 0);
      m_phase = go;
      m_pass  = (go == P_HALL) ? t : 0;
      m_butt  = (go == P_CAB) ? t : 0;
      if (t != 0 && t != e) m_dir = (t > e);
    end
    if (clr_h != 0) mh[clr_h] = 1'b0;
    if (clr_c != 0) mc[clr_c] = 1'b0;
    mh = mh | h;
    mc = mc | c;
  endfunction

  initial begin
    logic [N-1:0] c3;
    int car;

    // Hall 5 from floor 1, then cab 2/6/4 from floor 3 served 4, 6, 2.
    c3 = fm(2) | fm(4) | fm(6);
    addv(fm(5), '0, 1, 0, 0, 0, 1, fm(5), '0);
    addv('0, '0, 1, 0, 5, 0, 1, fm(5), '0);
    addv('0, '0, 5, 1, 5, 0, 1, fm(5), '0);
    addv('0, '0, 5, 0, 5, 0, 1, '0, '0);
    for (int k = 1; k < DW; k++) addv('0, '0, 5, 0, 5, 0, 1, '0, '0);
    addv('0, '0, 5, 0, 0, 0, 1, '0, '0);
    addv('0, c3, 3, 0, 0, 0, 1, '0, c3);
    addv('0, '0, 3, 0, 0, 4, 1, '0, c3);
    addv('0, '0, 4, 0, 0, 4, 1, '0, fm(2) | fm(6));
    for (int k = 1; k < DW; k++) addv('0, '0, 4, 0, 0, 4, 1, '0, fm(2) | fm(6));
    addv('0, '0, 4, 0, 0, 6, 1, '0, fm(2) | fm(6));
    addv('0, '0, 5, 1, 0, 6, 1, '0, fm(2) | fm(6));
    addv('0, '0, 6, 0, 0, 6, 1, '0, fm(2));
    for (int k = 1; k < DW; k++) addv('0, '0, 6, 0, 0, 6, 1, '0, fm(2));
    addv('0, '0, 6, 0, 0, 2, 0, '0, fm(2));
    addv('0, '0, 2, 0, 0, 2, 0, '0, '0);
    for (int k = 1; k < DW; k++) addv('0, '0, 2, 0, 0, 2, 0, '0, '0);
    addv('0, '0, 2, 0, 0, 0, 0, '0, '0);

    // Reset wins over a press on the same edge.
    rst = 1'b1;
    drive(fm(7), fm(3), 1, 1'b0);
    tick();
    tick();
    check_outs("reset", 0, 0, 1, '0, '0);
    rst = 1'b0;
    drive('0, '0, 1, 1'b0);

    foreach (vq[i]) begin
      drive(vq[i].hall, vq[i].cab, vq[i].elev, vq[i].busy);
      tick();
      check_outs($sformatf("vec%0d", i), vq[i].pass, vq[i].butt, vq[i].dir, vq[i].hp, vq[i].cp);
    end

    // Press on the clearing edge: set wins and the floor is served again.
    do_reset();
    drive(fm(4), '0, 1, 1'b0); tick();
    drive('0, '0, 1, 1'b0);    tick();
    chk("setwins.target", pass_f, 4);
    drive(fm(4), '0, 4, 1'b0); tick();
    chk("setwins.kept", hall_pend, fm(4));
    drive('0, '0, 4, 1'b0);
    repeat (DW) tick();
    chk("setwins.reserve", pass_f, 4);
    chk("setwins.still", hall_pend, fm(4));
    tick();
    chk("setwins.cleared", hall_pend, 0);
    repeat (DW) tick();
    chk("setwins.idle", pass_f, 0);

    // A floor pressed mid-travel does not preempt the current target.
    do_reset();
    drive('0, fm(6), 1, 1'b0); tick();
    drive('0, '0, 1, 1'b0);    tick();
    chk("freeze.first", butt_el, 6);
    drive('0, fm(5), 3, 1'b1); tick();
    chk("freeze.pend", cab_pend, fm(5) | fm(6));
    chk("freeze.hold", butt_el, 6);
    drive('0, '0, 4, 1'b1);    tick();
    chk("freeze.hold2", butt_el, 6);
    drive('0, '0, 6, 1'b0);    tick();
    chk("freeze.clr", cab_pend, fm(5));
    repeat (DW) tick();
    chk("freeze.next", butt_el, 5);
    chk("freeze.dir", dir_up, 0);

    // Reset in the middle of cab service with three pending floors.
    do_reset();
    drive('0, fm(1) | fm(2) | fm(3), 5, 1'b0); tick();
    drive('0, '0, 5, 1'b1); tick();
    chk("rstmid.target", butt_el, 3);
    chk("rstmid.dir", dir_up, 0);
    rst = 1'b1;
    tick();
    check_outs("rstmid", 0, 0, 1, '0, '0);
    rst = 1'b0;

    // Randomised traffic against the reference model with a simple moving car.
    do_reset();
    m_reset();
    car = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [N-1:0] hb, cb;
      int  tgt, e;
      bit  b;
      tgt = m_pass + m_butt;
      hb = ($urandom_range(0, 5) == 0) ? fm(int'($urandom_range(1, N))) : '0;
      cb = ($urandom_range(0, 5) == 0) ? fm(int'($urandom_range(1, N))) : '0;
      if (tgt != 0 && $urandom_range(0, 1) == 1) begin
        if (tgt > car) car++;
        else if (tgt < car) car--;
      end
      e = ($urandom_range(0, 19) == 0) ? 0 : car;
      b = (tgt != car) || ($urandom_range(0, 3) == 0);
      drive(hb, cb, e, b);
      @(posedge clk);
      m_step(hb, cb, e, b);
      #1;
      check_outs($sformatf("rnd%0d", cyc), m_pass, m_butt, m_dir, mh, mc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
